// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and a saturating stall counter.
// Define PIPE_SKID_EN to add the skid entry; that makes in_ready come straight from a flop.
module pipe_stage_skid #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign stall_cnt = stall_cnt_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid_q & out_ready;

`ifdef PIPE_SKID_EN

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e             occ;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;

    // in_ready is a flop output, so out_ready never reaches upstream combinationally.
    assign in_ready = !skid_valid_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        occ          = skid_valid_q ? OCC_FULL : (main_valid_q ? OCC_ONE : OCC_EMPTY);
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        main_valid_d = 1'b1;
                        main_data_d  = in_data;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                    end else if (out_fire) begin
                        main_valid_d = 1'b0;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

`else

    // Single entry: a full stage accepts only when it drains in the same cycle.
    assign in_ready = !main_valid_q | out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
        end else if (in_fire) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end
    end

`endif

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: payload registers are reset too, because downstream may see out_data while invalid.
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a FIFO model predicts handshake, payload order and stall count.
// Covers either build, depending on whether PIPE_SKID_EN is defined.
module tb_pipe_stage_skid;

    localparam int WIDTH    = 32;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] stall_cnt;

    int               total = 0;
    int               bad   = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               m_stall = 0;
    bit               acc;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_in_ready(input bit o_rdy);
`ifdef PIPE_SKID_EN
        return exp_q.size() < 2;
`else
        return (exp_q.size() == 0) || o_rdy;
`endif
    endfunction

    // One clock cycle: drive, check on the falling edge, advance the model at the rising edge.
    task automatic step(input bit iv, input logic [WIDTH-1:0] d, input bit ordy, input bit fl,
                        output bit accepted);
        bit m_ready;
        bit m_valid;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        m_ready = model_in_ready(ordy);
        m_valid = (exp_q.size() != 0);
        check("in_ready", in_ready, m_ready);
        check("out_valid", out_valid, m_valid);
        if (m_valid) check("out_data", out_data, exp_q[0]);
        check("stall_cnt", stall_cnt, m_stall);
        @(posedge clk);
        accepted = iv && m_ready && !fl;
        if (m_valid && !ordy && m_stall < CNT_MAX) m_stall++;
        if (m_valid && ordy) void'(exp_q.pop_front());
        if (fl) exp_q.delete();
        else if (iv && m_ready) exp_q.push_back(d);
        #1;
    endtask

    // Offer d until accepted; out_ready stays low for the first n_stall attempts.
    task automatic send(input logic [WIDTH-1:0] d, input int n_stall);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 12 && !ok; t++) step(1'b1, d, (t >= n_stall), 1'b0, ok);
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit a;
        for (int t = 0; t < 10 && exp_q.size() != 0; t++) step(1'b0, '0, 1'b1, 1'b0, a);
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, a);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_stall_cnt"}, stall_cnt, '0);
        check({tag, "_out_data"}, out_data, '0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming with out_ready held high.
        for (int i = 1; i <= 8; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0, acc);
        drain();

        // Back-pressure: 0xC is offered while out_ready is low, then downstream opens.
        step(1'b1, 32'hA, 1'b0, 1'b0, acc);
        send(32'hB, 2);
        send(32'hC, 2);
        drain();

        // Flush while full, with a simultaneous input that must be discarded.
        step(1'b1, 32'h11, 1'b0, 1'b0, acc);
        step(1'b1, 32'h22, 1'b0, 1'b0, acc);
        step(1'b1, 32'h33, 1'b0, 1'b1, acc);
        step(1'b0, '0, 1'b1, 1'b0, acc);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h40 + WIDTH'(i), 1'b1, 1'b0, acc);
        drain();

        // Counter saturation.
        step(1'b1, 32'h77, 1'b0, 1'b0, acc);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0, acc);
        check("stall_sat", stall_cnt, CNT_MAX);
        drain();
        check("stall_hold", stall_cnt, CNT_MAX);

        // Single-entry corner: full main, then out_ready and in_valid rise together.
        step(1'b1, 32'h66, 1'b0, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h5, 1'b1, 1'b0, acc);
        drain();

        // Asynchronous reset between edges while holding data.
        step(1'b1, 32'h44, 1'b0, 1'b0, acc);
        step(1'b1, 32'h55, 1'b0, 1'b0, acc);
        #1 rst = 1'b1;
        #1 check_reset_values("async_rst");
        exp_q.delete();
        m_stall = 0;
        #1 rst = 1'b0;
        step(1'b1, 32'h99, 1'b1, 1'b0, acc);
        drain();

        // Random traffic with occasional flush.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), WIDTH'($urandom), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0), acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
